// File: rtl/ps2_host_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_rx
//  Description : Core-side PS/2 receiver. Synchronises and filters the
//                emulated PS/2 clock/data pair, samples data on the filtered
//                clock falling edge and checks the start, odd-parity and stop
//                bits. Good bytes and dropped frames are reported as
//                single-cycle strobes. A mid-frame idle timeout aborts
//                stalled frames.
//                Optional macro PS2_SCANCODE_EN adds an E0/F0 prefix tracker
//                driving the key_* outputs; without it they are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_strobe
);

    localparam int              c_TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      c_FMAX = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt_clk, r_filt_clk_d, r_filt_dat;
    logic [3:0]      r_fcnt_clk, r_fcnt_dat;
    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_sr;
    logic            r_par;
    logic            r_perr;
    logic [c_TW-1:0] r_tcnt;
    logic            w_fall;
    logic            w_d;

    // Two-FF synchronisers; both lines idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Clock-line filter: adopt a new level after FILTER_LEN consecutive samples at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_clk <= 1'b1;
            r_fcnt_clk <= 4'd0;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_fcnt_clk <= 4'd0;
        end else if (r_fcnt_clk >= c_FMAX) begin
            r_filt_clk <= r_clk_s2;
            r_fcnt_clk <= 4'd0;
        end else begin
            r_fcnt_clk <= r_fcnt_clk + 4'd1;
        end
    end

    // Data-line filter, identical behaviour to the clock-line filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_dat <= 1'b1;
            r_fcnt_dat <= 4'd0;
        end else if (r_dat_s2 == r_filt_dat) begin
            r_fcnt_dat <= 4'd0;
        end else if (r_fcnt_dat >= c_FMAX) begin
            r_filt_dat <= r_dat_s2;
            r_fcnt_dat <= 4'd0;
        end else begin
            r_fcnt_dat <= r_fcnt_dat + 4'd1;
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) r_filt_clk_d <= 1'b1;
        else       r_filt_clk_d <= r_filt_clk;
    end

    assign w_fall = r_filt_clk_d & ~r_filt_clk;
    assign w_d    = r_filt_dat;
    assign busy   = (r_state != S_IDLE);

    // Frame state machine: advances on filtered clock falls, aborts on idle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_sr      <= 8'd0;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_tcnt    <= '0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (r_state == S_IDLE || w_fall) r_tcnt <= '0;
            else                             r_tcnt <= r_tcnt + 1'b1;

            if (r_state != S_IDLE && !w_fall && r_tcnt == c_TMAX) begin
                // Stalled transmitter: drop the partial frame.
                r_state  <= S_IDLE;
                rx_err   <= 1'b1;
                err_code <= 2'b11;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_d) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                            r_par     <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_sr  <= {w_d, r_sr[7:1]};
                        r_par <= r_par ^ w_d;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: begin
                        r_perr  <= ~(r_par ^ w_d);
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // A bad stop bit outranks a parity error.
                        if (!w_d) begin
                            rx_err   <= 1'b1;
                            err_code <= 2'b10;
                        end else if (r_perr) begin
                            rx_err   <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            rx_data  <= r_sr;
                            rx_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PS2_SCANCODE_EN
    logic r_ext_pend, r_rel_pend;

    // Prefix tracker: collect E0/F0 prefixes, publish them with the next key byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext_pend  <= 1'b0;
            r_rel_pend  <= 1'b0;
            key_code    <= 8'd0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_strobe  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_err) begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end else if (rx_valid) begin
                if (rx_data == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (rx_data == 8'hF0) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    key_code    <= rx_data;
                    key_ext     <= r_ext_pend;
                    key_release <= r_rel_pend;
                    key_strobe  <= 1'b1;
                    r_ext_pend  <= 1'b0;
                    r_rel_pend  <= 1'b0;
                end
            end
        end
    end
`else
    assign key_code    = 8'd0;
    assign key_ext     = 1'b0;
    assign key_release = 1'b0;
    assign key_strobe  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_rx
//  Description : Scoreboard bench for ps2_host_rx. A driver emits PS/2
//                frames and pushes the expected outcome; a monitor pops and
//                compares whenever the receiver pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_rx;

    localparam int c_FILTER  = 4;
    localparam int c_TIMEOUT = 600;
    localparam int c_HALF    = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err, busy;
    logic [1:0] err_code;
    logic [7:0] key_code;
    logic       key_ext, key_release, key_strobe;

    ps2_host_rx #(.FILTER_LEN(c_FILTER), .TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .err_code(err_code),
        .busy(busy), .key_code(key_code), .key_ext(key_ext),
        .key_release(key_release), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic is_err; logic [7:0] data; logic [1:0] code; } exp_t;
    typedef struct packed { logic [7:0] code; logic ext; logic rel; } key_t;

    exp_t q[$];
    key_t kq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_fall_cyc = 0;
    int   n_key_pulses = 0;
    logic [7:0] m_last_good = 8'd0;
    logic [1:0] m_last_code = 2'b00;
    logic       m_ext = 1'b0, m_rel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame outcome from start/parity/stop rules, plus prefix tracking.
    task automatic model_push(input logic is_err, input logic [7:0] data, input logic [1:0] code);
        exp_t e;
        key_t k;
        e.is_err = is_err; e.data = data; e.code = code;
        q.push_back(e);
        if (is_err) begin
            m_ext = 1'b0; m_rel = 1'b0;
        end else if (data == 8'hE0) begin
            m_ext = 1'b1;
        end else if (data == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            k.code = data; k.ext = m_ext; k.rel = m_rel;
            kq.push_back(k);
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [7:0] data, input logic par, input logic stop);
        if (!stop)                   model_push(1'b1, 8'h00, 2'b10);
        else if (par != ~(^data))    model_push(1'b1, 8'h00, 2'b01);
        else                         model_push(1'b0, data, 2'b00);
    endtask

    // One PS/2 bit: data changes while clock high, then a full low/high clock period.
    task automatic ps2_bit(input logic b, input logic glitch);
        @(posedge clk); #1;
        ps2_data = b;
        if (glitch) begin
            repeat (c_HALF / 2) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (2) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (c_HALF / 2) @(posedge clk);
        end else begin
            repeat (c_HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (c_HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, input int glitch_at);
        model_frame(data, par, stop);
        ps2_bit(1'b0, glitch_at == 0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i], glitch_at == i + 1);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, 1'b0);
        @(posedge clk); #1 ps2_data = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] data);
        send_frame(data, ~(^data), 1'b1, -1);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_err) check("valid_and_err_together", 32'd1, 32'd0);
            if (rx_valid || rx_err) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {rx_valid, rx_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pulse_kind_err", rx_err, e.is_err);
                    if (!e.is_err) begin
                        check("rx_data", rx_data, e.data);
                        check("err_code_held", err_code, m_last_code);
                        m_last_good = e.data;
                    end else begin
                        check("err_code", err_code, e.code);
                        check("rx_data_held", rx_data, m_last_good);
                        m_last_code = e.code;
                    end
                end
            end
`ifdef PS2_SCANCODE_EN
            if (key_strobe) begin
                if (kq.size() == 0) begin
                    check("unexpected_key_strobe", 32'd1, 32'd0);
                end else begin
                    key_t k;
                    k = kq.pop_front();
                    check("key_code", key_code, k.code);
                    check("key_ext", key_ext, k.ext);
                    check("key_release", key_release, k.rel);
                end
            end
`else
            if (key_strobe) n_key_pulses++;
`endif
        end
    end

    initial begin
        bit found;
        int hit_cyc;
        logic prev_busy;

        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_err", rx_err, 0);
        check("reset_err_code", err_code, 0);
        check("reset_busy", busy, 0);
        check("reset_key_strobe", key_strobe, 0);

        // Directed frames: good 1C, bad-parity 1C, bad-stop A5, good 5A.
        good_frame(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        good_frame(8'h5A);

        // Glitch on ps2_clk mid-frame must not disturb the frame.
        send_frame(8'h3C, ~(^8'h3C), 1'b1, 4);

        // Glitch in idle with data low must not start a frame.
        @(posedge clk); #1 ps2_data = 1'b0;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_glitch_busy", busy, 0);
        #1 ps2_data = 1'b1;
        good_frame(8'h81);

        // Timeout after start plus four data bits.
        model_push(1'b1, 8'h00, 2'b11);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
        found = 0; hit_cyc = 0; prev_busy = 1'b0;
        for (int k = 0; k < c_TIMEOUT + 100; k++) begin
            @(negedge clk);
            if (rx_err) begin found = 1; hit_cyc = cyc; break; end
            prev_busy = busy;
        end
        check("timeout_seen", found, 1);
        check("timeout_latency", hit_cyc - last_fall_cyc, c_TIMEOUT + c_FILTER + 3);
        check("timeout_busy_before", prev_busy, 1);
        check("timeout_busy_drop", busy, 0);
        @(posedge clk); #1 ps2_data = 1'b1;
        good_frame(8'h42);

        // Reset mid-frame: frame abandoned silently, outputs cleared.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        m_last_good = 8'd0; m_last_code = 2'b00; m_ext = 1'b0; m_rel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_err_code", err_code, 0);
        ps2_data = 1'b1;
        good_frame(8'h29);

        // Scancode prefixes: E0 F0 75, then a bare 75.
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h75);
        good_frame(8'h75);

        // Randomised frames with occasional parity/stop faults and random gaps.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic p, s;
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 9) < 7) ? ~(^d) : (^d);
            s = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            send_frame(d, p, s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1);
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end

        repeat (50) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
`ifdef PS2_SCANCODE_EN
        check("key_queue_drained", kq.size(), 0);
`else
        check("no_key_strobes", n_key_pulses, 0);
        check("key_outputs_zero", {key_code, key_ext, key_release}, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
